// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge D-type storage element, parameterisable width.
//
// Parameters
//   WIDTH       bit width of D and Q
//   RESET_VALUE value forced onto Q while reset is high
//
// Ports
//   CLK    in   1      clock; Q updates only on the rising edge
//   reset  in   1      asynchronous, active-high reset
//   D      in   WIDTH  data input, sampled on the CLK rising edge
//   Q      out  WIDTH  stored value; driven straight from the register, no path from D
module d_flip_flop #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  // Reset is in the sensitivity list, so it acts at once and also
  // overrides a CLK edge that arrives while it is high.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= D;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
module tb_d_flip_flop;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q;
  logic [7:0] d8;
  logic [7:0] q8;

  int total;
  int bad;

  localparam logic [7:0] RstVal8 = 8'hA5;

  d_flip_flop u_dut (
    .CLK   (clk),
    .reset (rst),
    .D     (d),
    .Q     (q)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .RESET_VALUE (RstVal8)
  ) u_dut8 (
    .CLK   (clk),
    .reset (rst),
    .D     (d8),
    .Q     (q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_both(input string name, input logic exp_q, input logic [7:0] exp_q8);
    check({name, " q"}, {7'b0, q}, {7'b0, exp_q});
    check({name, " q8"}, q8, exp_q8);
  endtask

  typedef struct {
    logic       rst;
    logic       d;
    logic [7:0] d8;
    logic       q;
    logic [7:0] q8;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       prev_q;
    logic [7:0] prev_q8;
    total = 0;
    bad   = 0;

    vecs[0] = '{1'b1, 1'b1, 8'h11, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h11};
    vecs[2] = '{1'b0, 1'b0, 8'h22, 1'b0, 8'h22};
    vecs[3] = '{1'b0, 1'b1, 8'hFE, 1'b1, 8'hFE};
    vecs[4] = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h01};
    vecs[5] = '{1'b1, 1'b0, 8'h77, 1'b0, 8'hA5};
    vecs[6] = '{1'b0, 1'b0, 8'h80, 1'b0, 8'h80};
    vecs[7] = '{1'b0, 1'b1, 8'h7F, 1'b1, 8'h7F};

    // Timed walk through the basic plan; rising edges at 5, 15, 25 ... ns.
    rst = 1'b0; d = 1'b0; d8 = 8'h00;
    #6;  check_both("first edge", 1'b0, 8'h00);            // t=6
    #4;  d = 1'b1; d8 = 8'h3C;                             // t=10
    #4;  check_both("hold before edge", 1'b0, 8'h00);      // t=14
    #2;  check_both("load 1", 1'b1, 8'h3C);                // t=16
    #4;  d = 1'b0; d8 = 8'hC3;                             // t=20
    #4;  check_both("mid-cycle D ignored", 1'b1, 8'h3C);   // t=24
    #2;  check_both("load 0", 1'b0, 8'hC3);                // t=26
    #14; rst = 1'b1; d = 1'b1; d8 = 8'hFF;                 // t=40
    #1;  check_both("async reset", 1'b0, RstVal8);         // t=41
    #5;  check_both("reset holds over edge", 1'b0, RstVal8); // t=46
    #4;  rst = 1'b0;                                       // t=50
    #4;  check_both("after release", 1'b0, RstVal8);       // t=54
    #2;  check_both("first load after release", 1'b1, 8'hFF); // t=56

    // Short reset pulse with no clock edge inside it.
    #11; rst = 1'b1;                                       // t=67
    #1;  check_both("pulse reset", 1'b0, RstVal8);         // t=68
    #1;  rst = 1'b0;                                       // t=69
    #3;  check_both("after pulse", 1'b0, RstVal8);         // t=72
    #4;  check_both("reload after pulse", 1'b1, 8'hFF);    // t=76

    // Reset rising in the same time step as a CLK edge with D differing.
    #2;  d = 1'b0; d8 = 8'h00;                             // t=78
    #8;  d = 1'b1; d8 = 8'h5A;                             // t=86
    @(posedge clk);                                        // t=95
    rst = 1'b1;
    #1;  check_both("reset vs edge", 1'b0, RstVal8);

    // Table-driven per-cycle vectors, driven on the falling edge.
    prev_q  = 1'b0;
    prev_q8 = RstVal8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      d   = vecs[i].d;
      d8  = vecs[i].d8;
      #1;
      if (vecs[i].rst) check_both($sformatf("vec%0d pre", i), 1'b0, RstVal8);
      else             check_both($sformatf("vec%0d pre", i), prev_q, prev_q8);
      @(posedge clk);
      #1;
      check_both($sformatf("vec%0d", i), vecs[i].q, vecs[i].q8);
      prev_q  = vecs[i].q;
      prev_q8 = vecs[i].q8;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Single-bit, rising-edge-triggered D-type storage element. Width is parameterisable for reuse as a small register.
- Has an asynchronous, active-high reset that forces the output to a parameterised reset value.
- Basic building block for sequential logic in the lab designs. Purely a storage element: no enable, no combinational path from D to Q.

Parameters:
- WIDTH, 1, bit width of D and Q.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q while reset is asserted.

Ports:
- CLK  input  1  clock; Q updates only on the rising edge.
- reset  input  1  asynchronous, active-high reset; forces Q to RESET_VALUE.
- D  input  WIDTH  data input, sampled on the CLK rising edge.
- Q  output  WIDTH  registered output; the stored value.

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high, port named reset.
- Reset assertion: on the rising edge of reset, Q goes to RESET_VALUE (default 0) immediately, with no wait for CLK.
- Reset held high:
  - Q remains RESET_VALUE.
  - CLK edges are ignored.
  - D is don't-care.
- Reset release: Q keeps RESET_VALUE after reset falls. It changes only at the next CLK rising edge where reset is low, and then takes D.
- Normal operation (reset low): at each CLK rising edge, Q <= D.
- Latency: one clock edge. D changes between edges have no effect on Q.
- CLK falling edges: no effect.
- Reset asserted coincident with a CLK rising edge: reset wins, Q = RESET_VALUE.
- Power-up: Q is unspecified (X in simulation) until the first reset assertion or the first CLK rising edge.
- No glitch or combinational path: Q depends only on the stored state.
- Implementation: a single always block sensitive to posedge CLK and posedge reset, using non-blocking assignment.

Test Plan:
Bench clock period is 10 ns, starting low, so rising edges fall at 5, 15, 25, 35, 45, 55 ns.
1. reset=0, D=0 from t=0 -> Q=0 after the edge at 5 ns.
2. D=1 at t=10 -> Q stays 0 until t=15, then Q=1 at t=15.
3. D=0 at t=20, between edges -> Q stays 1 until the edge at 25 ns, then Q=0.
4. reset=1 and D=1 at t=40 -> Q=0 immediately at t=40. Q stays 0 through the edge at 45 ns despite D=1.
5. reset=0 at t=50, D=1 held -> Q stays 0 during 50–55 ns, then Q=1 at the edge at 55 ns.
6. Set Q=1, then pulse reset high for 2 ns mid-cycle with no clock edge -> Q drops to 0 at the pulse. Q stays 0 until the next rising edge, then reloads D.
